// File: rtl/inst_rom_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_rom_loader_pkg
//   Shared definitions for the instruction ROM loader:
//     - instruction bus / address bus widths
//     - the zero word and the default NOP word (addi x0,x0,0)
//     - the loader FSM state encoding (3 bits)
//     - small helpers used by the loader
// -----------------------------------------------------------------------------
package inst_rom_loader_pkg;

    localparam int INST_BUS_W      = 32;
    localparam int INST_ADDR_BUS_W = 32;

    localparam logic [INST_BUS_W-1:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [INST_BUS_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0013;

    // Width of the word pointer and the widened word count. One bit wider
    // than the 16-bit header so pointer + 1 never wraps before it is
    // compared against the count.
    localparam int CNT_W = 17;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR0 = 3'd1,
        S_HDR1 = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } ld_state_e;

    // True in the states where the loader consumes stream bytes.
    function automatic logic state_accepts_bytes(input ld_state_e s);
        return (s == S_HDR0) || (s == S_HDR1) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/inst_rom_mem.sv
// -----------------------------------------------------------------------------
// inst_rom_mem
//   DEPTH x 32 instruction storage. Synchronous write, asynchronous read.
//   Holds only the array; contents are never cleared by reset.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   word write address
//   wdata  in   word to write
//   raddr  in   word read address
//   rdata  out  word at raddr (combinational)
// -----------------------------------------------------------------------------
module inst_rom_mem
    import inst_rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [INST_BUS_W-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [INST_BUS_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [INST_BUS_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// -----------------------------------------------------------------------------
// inst_rom_loader
//   Instruction memory in front of the core's fetch path, filled at run time
//   from a byte stream: a 16-bit little-endian word count, then that many
//   little-endian 32-bit words. run_o holds the core idle (fetches return
//   NOP_WORD) until a load has completed.
//
//   Load-port handshake: a byte is transferred on a rising clk edge where
//   ld_valid_i && ld_ready_o. ld_ready_o depends on the FSM state only, so a
//   producer may hold ld_valid_i high and the byte is taken on the first edge
//   where the loader is ready. ld_start_i wins over a simultaneous transfer;
//   that byte is dropped.
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   ld_start_i  in   pulse: begin / restart a load
//   ld_valid_i  in   ld_byte_i valid
//   ld_byte_i   in   stream byte
//   ld_ready_o  out  loader accepts a byte (HDR0, HDR1, DATA)
//   ld_err_o    out  sticky: header count exceeded DEPTH
//   run_o       out  load complete, core may fetch
//   ce_i        in   fetch enable
//   addr_i      in   byte fetch address
//   inst_o      out  instruction word (combinational)
//   dbg_state   out  current FSM state, for observation only
// -----------------------------------------------------------------------------
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [INST_BUS_W-1:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_start_i,
    input  logic                       ld_valid_i,
    input  logic [7:0]                 ld_byte_i,
    output logic                       ld_ready_o,
    output logic                       ld_err_o,
    output logic                       run_o,
    input  logic                       ce_i,
    input  logic [INST_ADDR_BUS_W-1:0] addr_i,
    output logic [INST_BUS_W-1:0]      inst_o,
    output logic [2:0]                 dbg_state
);

    localparam int               DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    ld_state_e        state;
    logic             run_q;
    logic             err_q;
    logic [1:0]       byte_k;   // byte index within the word being assembled
    logic [23:0]      asm_q;    // bytes 0..2 of the word being assembled
    logic [CNT_W-1:0] ptr_q;    // next word index to write
    logic [15:0]      count_q;  // word count from the header

    // -------------------------------------------------------------------------
    // Stream decode
    // -------------------------------------------------------------------------
    logic                  xfer;
    logic [15:0]           hdr_count;
    logic [CNT_W-1:0]      ptr_next;
    logic                  word_done;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [INST_BUS_W-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] mem_raddr;
    logic [INST_BUS_W-1:0] mem_rdata;

    assign ld_ready_o = state_accepts_bytes(state);
    assign xfer       = ld_valid_i && ld_ready_o;

    // Full count as it becomes known on the HDR1 transfer.
    assign hdr_count  = {ld_byte_i, count_q[7:0]};
    assign ptr_next   = ptr_q + CNT_W'(1);

    // The 4th byte completes the word; the write happens on that same edge,
    // using the incoming byte directly as the top byte.
    assign word_done  = xfer && !ld_start_i && (state == S_DATA) && (byte_k == 2'd3);

    // Words beyond the array are consumed from the stream but not stored.
    assign mem_we     = word_done && (ptr_q < DEPTH_W);
    assign mem_waddr  = ptr_q[ADDR_WIDTH-1:0];
    assign mem_wdata  = {ld_byte_i, asm_q};

    // -------------------------------------------------------------------------
    // Loader FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            run_q   <= 1'b0;
            err_q   <= 1'b0;
            byte_k  <= 2'd0;
            asm_q   <= 24'd0;
            ptr_q   <= '0;
            count_q <= 16'd0;
        end else if (ld_start_i) begin
            // Restart from any state; a byte offered in this cycle is dropped.
            state  <= S_HDR0;
            run_q  <= 1'b0;
            err_q  <= 1'b0;
            ptr_q  <= '0;
            byte_k <= 2'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Wait for ld_start_i.
                end

                S_HDR0: begin
                    if (xfer) begin
                        count_q[7:0] <= ld_byte_i;
                        state        <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (xfer) begin
                        count_q[15:8] <= ld_byte_i;
                        if (hdr_count == 16'd0) begin
                            state <= S_DONE;
                            run_q <= 1'b1;
                        end else begin
                            state <= S_DATA;
                            err_q <= ({1'b0, hdr_count} > DEPTH_W);
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        case (byte_k)
                            2'd0: asm_q[7:0]   <= ld_byte_i;
                            2'd1: asm_q[15:8]  <= ld_byte_i;
                            2'd2: asm_q[23:16] <= ld_byte_i;
                            default: begin
                                // Word complete: memory write happens via mem_we.
                            end
                        endcase

                        if (byte_k == 2'd3) begin
                            byte_k <= 2'd0;
                            ptr_q  <= ptr_next;
                            if (ptr_next == {1'b0, count_q}) begin
                                state <= S_DONE;
                                run_q <= 1'b1;
                            end
                        end else begin
                            byte_k <= byte_k + 2'd1;
                        end
                    end
                end

                S_DONE: begin
                    // Hold until ld_start_i or reset.
                end

                default: begin
                    state <= S_IDLE;
                    run_q <= 1'b0;
                end
            endcase
        end
    end

    assign run_o     = run_q;
    assign ld_err_o  = err_q;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    assign mem_raddr = addr_i[ADDR_WIDTH+1:2];

    inst_rom_mem #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // -------------------------------------------------------------------------
    // Fetch path (combinational). During a load the core only ever sees
    // NOP_WORD, so a fetch can never observe a word that is being written.
    // -------------------------------------------------------------------------
    logic addr_out_of_range;
    assign addr_out_of_range = (addr_i[INST_ADDR_BUS_W-1:ADDR_WIDTH+2] != '0);

    always_comb begin
        inst_o = ZERO_WORD;
        if (!ce_i) begin
            inst_o = ZERO_WORD;
        end else if (!run_q) begin
            inst_o = NOP_WORD;
        end else if (addr_out_of_range) begin
            inst_o = ZERO_WORD;
        end else begin
            inst_o = mem_rdata;
        end
    end

    // Byte offset within a word is irrelevant to word fetches.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

    localparam int          AW    = 10;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_byte_i;
    logic        ld_ready_o;
    logic        ld_err_o;
    logic        run_o;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [31:0] inst_o;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: memory contents as the core should see them, and
    // whether a complete load has happened since the last start/reset.
    logic [31:0] model_mem [DEPTH];
    bit          model_run;
    logic [31:0] word_q [$];

    inst_rom_loader #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld_start_i (ld_start_i),
        .ld_valid_i (ld_valid_i),
        .ld_byte_i  (ld_byte_i),
        .ld_ready_o (ld_ready_o),
        .ld_err_o   (ld_err_o),
        .run_o      (run_o),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .inst_o     (inst_o),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [31:0] exp_inst(input bit ce, input logic [31:0] a);
        if (!ce) return 32'h0;
        if (!model_run) return NOP;
        if (a[31:12] != 20'h0) return 32'h0;
        return model_mem[a[11:2]];
    endfunction

    // A complete load of word_q: the first DEPTH words land in memory.
    task automatic model_load(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < DEPTH) model_mem[i] = word_q[i];
        end
        model_run = 1;
    endtask

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int n;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            ld_valid_i = 1'b0;
            ld_byte_i  = 8'($urandom);
        end
        @(negedge clk);
        ld_valid_i = 1'b1;
        ld_byte_i  = b;
        n = 0;
        while (!ld_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = ld_ready_o;
        if (ok) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_words(input int cnt, input int gap_max, output int lost);
        bit          ok;
        logic [31:0] w;
        logic [15:0] c;
        lost = 0;
        c = 16'(cnt);
        send_byte(c[7:0], $urandom_range(gap_max, 0), ok);  if (!ok) lost++;
        send_byte(c[15:8], $urandom_range(gap_max, 0), ok); if (!ok) lost++;
        foreach (word_q[i]) begin
            w = word_q[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], $urandom_range(gap_max, 0), ok);
                if (!ok) lost++;
            end
        end
        @(negedge clk);
        ld_valid_i = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ld_start_i = 1'b1;
        @(posedge clk);
        #1;
        ld_start_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (run_o !== 1'b0) begin errors++; $display("FAIL reset_run got=%b exp=0", run_o); end
        checks++; if (ld_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ld_ready_o); end
        checks++; if (ld_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", ld_err_o); end
        ce_i = 1'b1; addr_i = 32'h0; #1;
        checks++; if (inst_o !== 32'h0000_0013) begin errors++; $display("FAIL reset_nop got=%h exp=00000013", inst_o); end
        ce_i = 1'b0; #1;
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL reset_ce0 got=%h exp=00000000", inst_o); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ld_ready_o !== 1'b0 || run_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset ready=%b run=%b exp=0/0", ld_ready_o, run_o); end
    endtask

    task automatic test_basic_load();
        logic [7:0] s [10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
        logic [31:0] a;
        bit ok;
        pulse_start();
        checks++; if (ld_ready_o !== 1'b1 || run_o !== 1'b0) begin errors++; $display("FAIL basic_start ready=%b run=%b exp=1/0", ld_ready_o, run_o); end
        for (int i = 0; i < 10; i++) begin
            send_byte(s[i], 0, ok);
            checks++; if (!ok) begin errors++; $display("FAIL basic_timeout byte=%0d", i); end
            checks++; if (run_o !== (i == 9)) begin errors++; $display("FAIL basic_run byte=%0d got=%b exp=%b", i, run_o, (i == 9)); end
        end
        @(negedge clk); ld_valid_i = 1'b0;
        word_q = {{s[5], s[4], s[3], s[2]}, {s[9], s[8], s[7], s[6]}};
        model_load(2);
        checks++; if (ld_ready_o !== 1'b0 || ld_err_o !== 1'b0) begin errors++; $display("FAIL basic_done ready=%b err=%b exp=0/0", ld_ready_o, ld_err_o); end
        ce_i = 1'b1;
        foreach (a[i]) ; // no-op to keep a declared before use
        a = 32'd0; addr_i = a; #1;
        checks++; if (inst_o !== 32'h0010_0093) begin errors++; $display("FAIL basic_rd0 got=%h exp=00100093", inst_o); end
        a = 32'd4; addr_i = a; #1;
        checks++; if (inst_o !== 32'h0020_0113) begin errors++; $display("FAIL basic_rd4 got=%h exp=00200113", inst_o); end
        a = 32'd5; addr_i = a; #1;
        checks++; if (inst_o !== 32'h0020_0113) begin errors++; $display("FAIL basic_rd5 got=%h exp=00200113", inst_o); end
        ce_i = 1'b0; #1;
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL basic_ce0 got=%h exp=0", inst_o); end
    endtask

    task automatic test_gaps();
        int lost, cnt;
        logic [31:0] a;
        // Same two-word stream with random idle gaps.
        pulse_start();
        word_q = {32'h0010_0093, 32'h0020_0113};
        send_words(2, 3, lost);
        checks++; if (lost !== 0) begin errors++; $display("FAIL gaps_timeout lost=%0d exp=0", lost); end
        checks++; if (run_o !== 1'b1) begin errors++; $display("FAIL gaps_run got=%b exp=1", run_o); end
        ce_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            addr_i = 32'(i * 4) | 32'($urandom_range(3, 0)); #1;
            checks++; if (inst_o !== word_q[i]) begin errors++; $display("FAIL gaps_rd idx=%0d got=%h exp=%h", i, inst_o, word_q[i]); end
        end
        // Random-length load of random words with random gaps.
        for (int r = 0; r < 3; r++) begin
            cnt = $urandom_range(16, 1);
            word_q.delete();
            for (int i = 0; i < cnt; i++) word_q.push_back($urandom);
            pulse_start();
            model_run = 0;
            send_words(cnt, 2, lost);
            model_load(cnt);
            checks++; if (lost !== 0) begin errors++; $display("FAIL rand_timeout lost=%0d exp=0", lost); end
            checks++; if (run_o !== 1'b1) begin errors++; $display("FAIL rand_run got=%b exp=1", run_o); end
            for (int i = 0; i < cnt; i++) begin
                a = 32'(i * 4) | 32'($urandom_range(3, 0));
                addr_i = a; #1;
                checks++; if (inst_o !== exp_inst(1, a)) begin errors++; $display("FAIL rand_rd addr=%h got=%h exp=%h", a, inst_o, exp_inst(1, a)); end
            end
        end
    endtask

    task automatic test_zero_header();
        bit ok;
        pulse_start();
        model_run = 0;
        checks++; if (run_o !== 1'b0) begin errors++; $display("FAIL zero_run_fall got=%b exp=0", run_o); end
        send_byte(8'h00, 0, ok);
        checks++; if (!ok || run_o !== 1'b0) begin errors++; $display("FAIL zero_byte0 ok=%b run=%b exp=1/0", ok, run_o); end
        send_byte(8'h00, 0, ok);
        @(negedge clk); ld_valid_i = 1'b0;
        model_run = 1;
        checks++; if (!ok || run_o !== 1'b1 || ld_ready_o !== 1'b0) begin errors++; $display("FAIL zero_done ok=%b run=%b ready=%b exp=1/1/0", ok, run_o, ld_ready_o); end
        ce_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            addr_i = 32'(i * 4); #1;
            checks++; if (inst_o !== exp_inst(1, addr_i)) begin errors++; $display("FAIL zero_keep addr=%h got=%h exp=%h", addr_i, inst_o, exp_inst(1, addr_i)); end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int lost;
        logic [31:0] w, a;
        word_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) word_q.push_back($urandom);
        word_q[DEPTH] = ~word_q[0];
        pulse_start();
        model_run = 0;
        send_byte(8'h01, 0, ok); if (!ok) lost++;
        send_byte(8'h04, 0, ok);
        checks++; if (!ok || ld_err_o !== 1'b1 || ld_ready_o !== 1'b1) begin errors++; $display("FAIL ovf_err ok=%b err=%b ready=%b exp=1/1/1", ok, ld_err_o, ld_ready_o); end
        lost = 0;
        foreach (word_q[i]) begin
            w = word_q[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], 0, ok);
                if (!ok) lost++;
            end
        end
        @(negedge clk); ld_valid_i = 1'b0;
        model_load(DEPTH + 1);
        checks++; if (lost !== 0 || run_o !== 1'b1) begin errors++; $display("FAIL ovf_run lost=%0d run=%b exp=0/1", lost, run_o); end
        checks++; if (ld_err_o !== 1'b1) begin errors++; $display("FAIL ovf_err_sticky got=%b exp=1", ld_err_o); end
        ce_i = 1'b1;
        addr_i = 32'h0; #1;
        checks++; if (inst_o !== word_q[0]) begin errors++; $display("FAIL ovf_mem0 got=%h exp=%h", inst_o, word_q[0]); end
        addr_i = 32'h0000_0FFC; #1;
        checks++; if (inst_o !== word_q[DEPTH-1]) begin errors++; $display("FAIL ovf_last got=%h exp=%h", inst_o, word_q[DEPTH-1]); end
        addr_i = 32'h0000_1000; #1;
        checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL ovf_oob got=%h exp=0", inst_o); end
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            if (i < 12) a[31:12] = 20'h0;
            addr_i = a; #1;
            checks++; if (inst_o !== exp_inst(1, a)) begin errors++; $display("FAIL ovf_rd addr=%h got=%h exp=%h", a, inst_o, exp_inst(1, a)); end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int lost;
        logic [31:0] wa, wb;
        wa = $urandom; wb = $urandom;
        pulse_start();
        model_run = 0;
        send_byte(8'h03, 0, ok); send_byte(8'h00, 0, ok);
        for (int k = 0; k < 4; k++) send_byte(wa[8*k +: 8], 0, ok);
        send_byte(wb[7:0], 0, ok); send_byte(wb[15:8], 0, ok);
        model_mem[0] = wa;
        // Restart with a byte offered in the same cycle; it must be dropped.
        @(negedge clk);
        ld_start_i = 1'b1; ld_valid_i = 1'b1; ld_byte_i = 8'h05;
        @(posedge clk); #1;
        ld_start_i = 1'b0;
        checks++; if (ld_ready_o !== 1'b1 || run_o !== 1'b0) begin errors++; $display("FAIL abort_restart ready=%b run=%b exp=1/0", ld_ready_o, run_o); end
        word_q = {32'($urandom), 32'($urandom)};
        send_words(2, 1, lost);
        model_load(2);
        checks++; if (lost !== 0 || run_o !== 1'b1) begin errors++; $display("FAIL abort_reload lost=%0d run=%b exp=0/1", lost, run_o); end
        ce_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            addr_i = 32'(i * 4); #1;
            checks++; if (inst_o !== exp_inst(1, addr_i)) begin errors++; $display("FAIL abort_rd idx=%0d got=%h exp=%h", i, inst_o, exp_inst(1, addr_i)); end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        int lost;
        logic [31:0] w;
        pulse_start();
        model_run = 0;
        send_byte(8'hD0, 0, ok); send_byte(8'h07, 0, ok);   // count 2000
        checks++; if (ld_err_o !== 1'b1) begin errors++; $display("FAIL areset_err_set got=%b exp=1", ld_err_o); end
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 0, ok);
            model_mem[i] = w;
        end
        send_byte(8'hEE, 0, ok);
        // Assert reset between edges; outputs must respond without a clock edge.
        @(negedge clk); ld_valid_i = 1'b0; #2;
        rst = 1'b0; #1;
        checks++; if (ld_ready_o !== 1'b0 || ld_err_o !== 1'b0 || run_o !== 1'b0) begin errors++; $display("FAIL areset_mid ready=%b err=%b run=%b exp=0/0/0", ld_ready_o, ld_err_o, run_o); end
        ce_i = 1'b1; addr_i = 32'h0; #1;
        checks++; if (inst_o !== NOP) begin errors++; $display("FAIL areset_nop got=%h exp=%h", inst_o, NOP); end
        @(negedge clk); rst = 1'b1;
        // Fresh shorter load; word 2 of the aborted load must persist.
        word_q = {32'($urandom), 32'($urandom)};
        pulse_start();
        send_words(2, 0, lost);
        model_load(2);
        checks++; if (lost !== 0 || run_o !== 1'b1 || ld_err_o !== 1'b0) begin errors++; $display("FAIL areset_reload lost=%0d run=%b err=%b exp=0/1/0", lost, run_o, ld_err_o); end
        for (int i = 0; i < 3; i++) begin
            addr_i = 32'(i * 4); #1;
            checks++; if (inst_o !== exp_inst(1, addr_i)) begin errors++; $display("FAIL areset_rd idx=%0d got=%h exp=%h", i, inst_o, exp_inst(1, addr_i)); end
        end
        // Reset from DONE also drops run_o immediately.
        @(negedge clk); #2;
        rst = 1'b0; model_run = 0; #1;
        checks++; if (run_o !== 1'b0) begin errors++; $display("FAIL areset_done run=%b exp=0", run_o); end
        @(negedge clk); rst = 1'b1;
        word_q = {32'($urandom)};
        pulse_start();
        send_words(1, 2, lost);
        model_load(1);
        addr_i = 32'h0; #1;
        checks++; if (lost !== 0 || run_o !== 1'b1 || inst_o !== exp_inst(1, 32'h0)) begin errors++; $display("FAIL areset_final lost=%0d run=%b got=%h exp=%h", lost, run_o, inst_o, exp_inst(1, 32'h0)); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        ld_start_i = 1'b0;
        ld_valid_i = 1'b0;
        ld_byte_i  = 8'h00;
        ce_i       = 1'b0;
        addr_i     = 32'h0;
        model_run  = 0;
        test_reset();
        test_basic_load();
        test_gaps();
        test_zero_header();
        test_overflow();
        test_abort();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
